// File: rtl/dpll_pkg.sv
// Shared DPLL types and constants for the phase detector and frequency generator.
package dpll_pkg;

    localparam int DPLL_N_BIT = 12;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pd_state_t;

endpackage

// File: rtl/phase_detector_edge_sync.sv
// edge_sync: two-flop synchroniser for an asynchronous pin plus a registered
// rising-edge pulse, one Clock cycle wide.
module edge_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic pin,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], pin};
            rise   <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/phase_detector.sv
// phase_detector: measures the reference period and the ref/fb phase error once per period.
// Optional macro PD_DEADBAND_EN: phase errors <= DEADBAND are reported as zero.
//
// state   | meaning
// IDLE    | waiting for a ref edge to start a period (after reset or timeout)
// MEASURE | counting a reference period, capturing the first fb edge
module phase_detector
    import dpll_pkg::*;
#(
    parameter int N_BIT    = DPLL_N_BIT,
    parameter int TIMEOUT  = 4000,
    parameter int DEADBAND = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic [N_BIT-1:0] f_in,
    output logic [N_BIT-1:0] diff_1,
    output logic [N_BIT-1:0] diff_2,
    output logic             first_second,
    output logic             ready,
    output logic             timeout
);

`ifdef PD_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    localparam logic [N_BIT-1:0] TO_CNT = N_BIT'(TIMEOUT);
    localparam logic [N_BIT-1:0] DB_CNT = N_BIT'(DEADBAND);
    localparam logic [N_BIT-1:0] MIN_P  = N_BIT'(4);
    localparam logic [N_BIT-1:0] ONE    = N_BIT'(1);

    pd_state_t        state;
    logic             ref_edge;
    logic             fb_edge;
    logic [N_BIT-1:0] per_cnt;
    logic [N_BIT-1:0] ph_cnt;
    logic             fb_seen;
    logic [N_BIT-1:0] half_p;
    logic [N_BIT-1:0] nx_f_in;
    logic [N_BIT-1:0] nx_diff_1;
    logic [N_BIT-1:0] nx_diff_2;
    logic             nx_fs;

    edge_sync u_ref_sync (
        .Clock (Clock),
        .Reset (Reset),
        .pin   (ref_in),
        .rise  (ref_edge)
    );

    edge_sync u_fb_sync (
        .Clock (Clock),
        .Reset (Reset),
        .pin   (fb_in),
        .rise  (fb_edge)
    );

    // Result for the period closing now; per_cnt holds its length P.
    always_comb begin
        half_p    = per_cnt >> 1;
        nx_f_in   = half_p - ONE;
        nx_diff_2 = {{(N_BIT-1){1'b0}}, per_cnt[0]};
        nx_diff_1 = '0;
        nx_fs     = 1'b0;
        if (fb_seen) begin
            if (ph_cnt <= half_p) begin
                nx_diff_1 = ph_cnt;
            end else begin
                nx_diff_1 = per_cnt - ph_cnt;
                nx_fs     = 1'b1;
            end
        end
        if (DB_EN && (nx_diff_1 <= DB_CNT)) begin
            nx_diff_1 = '0;
            nx_fs     = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            per_cnt      <= '0;
            ph_cnt       <= '0;
            fb_seen      <= 1'b0;
            f_in         <= '0;
            diff_1       <= '0;
            diff_2       <= '0;
            first_second <= 1'b0;
            ready        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            ready   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_edge) begin
                        state   <= MEASURE;
                        per_cnt <= ONE;
                        ph_cnt  <= '0;
                        fb_seen <= fb_edge;
                    end
                end
                MEASURE: begin
                    if (ref_edge) begin
                        if (per_cnt >= MIN_P) begin
                            f_in         <= nx_f_in;
                            diff_1       <= nx_diff_1;
                            diff_2       <= nx_diff_2;
                            first_second <= nx_fs;
                            ready        <= 1'b1;
                        end
                        // A coincident fb edge opens the new period with zero phase error.
                        per_cnt <= ONE;
                        ph_cnt  <= '0;
                        fb_seen <= fb_edge;
                    end else if (per_cnt >= TO_CNT) begin
                        timeout      <= 1'b1;
                        diff_1       <= '0;
                        diff_2       <= '0;
                        first_second <= 1'b0;
                        state        <= IDLE;
                        per_cnt      <= '0;
                        ph_cnt       <= '0;
                        fb_seen      <= 1'b0;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                        if (fb_edge && !fb_seen) begin
                            ph_cnt  <= per_cnt;
                            fb_seen <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: directed scenarios plus random periods
// checked every cycle against a period/offset arithmetic model.
module tb_phase_detector;

    localparam int NB = 12;
    localparam int TO = 4000;
    localparam int DB = 1;

    typedef struct {
        int            due;
        bit            is_to;
        logic [NB-1:0] f;
        logic [NB-1:0] d1;
        logic [NB-1:0] d2;
        bit            fs;
    } ev_t;

    logic          Clock;
    logic          Reset;
    logic          ref_in;
    logic          fb_in;
    logic [NB-1:0] f_in;
    logic [NB-1:0] diff_1;
    logic [NB-1:0] diff_2;
    logic          first_second;
    logic          ready;
    logic          timeout;

    int            total;
    int            bad;
    int            cyc;
    int            to_seen;
    int            last_ref;
    int            fb_first;
    bit            armed;
    logic [NB-1:0] m_f;
    logic [NB-1:0] m_d1;
    logic [NB-1:0] m_d2;
    bit            m_fs;
    ev_t           evq[$];

    phase_detector #(
        .N_BIT    (NB),
        .TIMEOUT  (TO),
        .DEADBAND (DB)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ref_in       (ref_in),
        .fb_in        (fb_in),
        .f_in         (f_in),
        .diff_1       (diff_1),
        .diff_2       (diff_2),
        .first_second (first_second),
        .ready        (ready),
        .timeout      (timeout)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Compare all outputs with the model; events become visible 4 steps after the pin edge.
    task automatic check_outputs();
        bit er;
        bit et;
        er = 1'b0;
        et = 1'b0;
        if (evq.size() > 0 && evq[0].due == cyc) begin
            if (evq[0].is_to) begin
                et   = 1'b1;
                m_d1 = '0;
                m_d2 = '0;
                m_fs = 1'b0;
            end else begin
                er   = 1'b1;
                m_f  = evq[0].f;
                m_d1 = evq[0].d1;
                m_d2 = evq[0].d2;
                m_fs = evq[0].fs;
            end
            void'(evq.pop_front());
        end
        if (timeout === 1'b1) to_seen++;
        chk("ready", ready, er);
        chk("timeout", timeout, et);
        chk("f_in", f_in, m_f);
        chk("diff_1", diff_1, m_d1);
        chk("diff_2", diff_2, m_d2);
        chk("first_second", first_second, m_fs);
    endtask

    task automatic model_update(input bit r, input bit f);
        int  p;
        int  o;
        int  half;
        ev_t e;
        if (armed && !r && (cyc - last_ref) == TO) begin
            e.due = cyc + 4; e.is_to = 1'b1;
            e.f = '0; e.d1 = '0; e.d2 = '0; e.fs = 1'b0;
            evq.push_back(e);
            armed = 1'b0;
        end
        if (r) begin
            if (armed) begin
                p = cyc - last_ref;
                if (p >= 4) begin
                    half    = p / 2;
                    e.due   = cyc + 4;
                    e.is_to = 1'b0;
                    e.f     = NB'(half - 1);
                    e.d2    = NB'(p % 2);
                    e.d1    = '0;
                    e.fs    = 1'b0;
                    if (fb_first >= 0) begin
                        o = fb_first - last_ref;
                        if (o <= half) begin
                            e.d1 = NB'(o);
                        end else begin
                            e.d1 = NB'(p - o);
                            e.fs = 1'b1;
                        end
                    end
`ifdef PD_DEADBAND_EN
                    if (e.d1 <= NB'(DB)) begin
                        e.d1 = '0;
                        e.fs = 1'b0;
                    end
`endif
                    evq.push_back(e);
                end
            end
            armed    = 1'b1;
            last_ref = cyc;
            fb_first = -1;
        end
        if (f && armed && fb_first < 0) fb_first = cyc;
    endtask

    task automatic step(input bit r, input bit f);
        @(negedge Clock);
        check_outputs();
        model_update(r, f);
        Reset  = 1'b0;
        ref_in = r;
        fb_in  = f;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check_outputs();
            evq.delete();
            armed = 1'b0;
            m_f = '0; m_d1 = '0; m_d2 = '0; m_fs = 1'b0;
            Reset  = 1'b1;
            ref_in = 1'b0;
            fb_in  = 1'b0;
            cyc++;
        end
    endtask

    // One reference period of p steps; fb pulses at offset fo (-1: no fb).
    task automatic period(input int p, input int fo);
        for (int k = 0; k < p; k++) step(k == 0, k == fo);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        int p;
        int fo;
        total = 0; bad = 0; cyc = 0; to_seen = 0;
        armed = 1'b0; last_ref = 0; fb_first = -1;
        m_f = '0; m_d1 = '0; m_d2 = '0; m_fs = 1'b0;
        Reset = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
        do_reset(3);
        chk("rst_f_in", f_in, 0);
        chk("rst_ready", ready, 0);

        for (int i = 0; i < 4; i++) period(100, 0);
        idle(5);
        chk("aligned_f_in", f_in, 49);
        chk("aligned_diff_1", diff_1, 0);
        chk("aligned_diff_2", diff_2, 0);

        for (int i = 0; i < 3; i++) period(100, 7);
        idle(5);
        chk("lag7_diff_1", diff_1, 7);
        chk("lag7_fs", first_second, 0);

        for (int i = 0; i < 3; i++) period(100, 90);
        idle(5);
        chk("lead10_diff_1", diff_1, 10);
        chk("lead10_fs", first_second, 1);

        period(101, -1);
        period(101, -1);
        idle(5);
        chk("odd_f_in", f_in, 49);
        chk("odd_diff_2", diff_2, 1);
        chk("nofb_diff_1", diff_1, 0);

        period(100, 7);
        period(100, 7);
        period(3, -1);
        period(3, -1);
        chk("short_held_diff_1", diff_1, 7);
        period(100, 7);
        period(100, 7);

        period(100, 7);
        idle(4100);
        chk("timeout_count", to_seen, 1);
        chk("timeout_f_in_held", f_in, 49);
        chk("timeout_diff_1", diff_1, 0);

        period(100, 90);
        period(100, 7);
        idle(5);
        chk("restart_diff_1", diff_1, 10);
        chk("restart_fs", first_second, 1);

        period(100, 7);
        for (int k = 0; k < 50; k++) step(k == 0, k == 7);
        do_reset(2);
        chk("midrst_f_in", f_in, 0);
        chk("midrst_diff_1", diff_1, 0);
        period(100, 7);
        period(100, 7);
        idle(5);
        chk("rearm_f_in", f_in, 49);
        chk("rearm_diff_1", diff_1, 7);

        period(100, 1);
        period(100, 1);
        idle(5);
`ifdef PD_DEADBAND_EN
        chk("lag1_diff_1", diff_1, 0);
`else
        chk("lag1_diff_1", diff_1, 1);
`endif
        period(100, 2);
        period(100, 2);
        idle(5);
        chk("lag2_diff_1", diff_1, 2);

        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(150, 20));
            if ($urandom_range(3, 0) == 0) fo = -1;
            else fo = int'($urandom_range(p - 2, 0));
            period(p, fo);
        end
        period(100, 7);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
